shared_mem_responder: RTL and testbench

Shared-memory responder serving the load/store request interface of all GPU cores. Each core's `mem_req_ld`/`mem_req_st`, `addr_shared_memory` and `mem_dat_st` lines land here. The block arbitrates them round-robin, performs one access per grant against a 2^ADDR_W x DATA_W synchronous RAM, and returns a one-cycle `val_data` pulse to the granted core, together with read data on a shared bus. It sits between the core array and the shared memory, with one instance per GPU.

---
 rtl/shared_mem_responder_if.sv | 48 ++++
 rtl/shared_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_shared_mem_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : shared_mem_responder_if
//  Description : Core-array side bundle for the shared-memory responder:
//                per-core load/store request lines, addresses, store data,
//                and the one-hot completion pulse / shared read-data return.
//                The served-access counters exist only when SHMEM_PERF_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface shared_mem_responder_if #(
  parameter int NCORES = 16,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [NCORES-1:0]        req_ld;
  logic [NCORES-1:0]        req_st;
  logic [NCORES*ADDR_W-1:0] addr;
  logic [NCORES*DATA_W-1:0] wdata;
  logic [NCORES-1:0]        val_data;
  logic [DATA_W-1:0]        rdata;
  logic                     busy;
`ifdef SHMEM_PERF_EN
  logic [15:0]              ld_count;
  logic [15:0]              st_count;

  modport master (
    output req_ld, req_st, addr, wdata,
    input  val_data, rdata, busy, ld_count, st_count
  );

  modport slave (
    input  req_ld, req_st, addr, wdata,
    output val_data, rdata, busy, ld_count, st_count
  );
`else
  modport master (
    output req_ld, req_st, addr, wdata,
    input  val_data, rdata, busy
  );

  modport slave (
    input  req_ld, req_st, addr, wdata,
    output val_data, rdata, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/shared_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : shared_mem_responder
//  Description : Round-robin arbiter plus single-port synchronous RAM that
//                serves load/store requests from NCORES cores, one access
//                per grant (IDLE -> ACCESS -> RESP). The granted core gets a
//                one-cycle val_data pulse with load data on the shared rdata
//                bus. Optional served-access counters: define SHMEM_PERF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module shared_mem_responder #(
  parameter int NCORES = 16,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input wire clk,
  input wire reset,
  shared_mem_responder_if.slave bus
);

  localparam int c_idx_w     = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int c_mem_depth = 1 << ADDR_W;
  localparam logic [c_idx_w:0] c_ncores = (c_idx_w+1)'(NCORES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [c_mem_depth];

  logic [c_idx_w-1:0]  r_rr_ptr;
  logic [c_idx_w-1:0]  r_gnt;
  logic [c_idx_w-1:0]  w_gnt_idx;
  logic                w_found;
  logic [NCORES-1:0]   w_elig;
  logic [NCORES-1:0]   r_holdoff;
  logic [NCORES-1:0]   r_val_data;
  logic                r_op_ld;
  logic [ADDR_W-1:0]   r_addr_l;
  logic [DATA_W-1:0]   r_wdata_l;
  logic [DATA_W-1:0]   r_rdata;

  // Reduce an index in [0, 2*NCORES) back into [0, NCORES).
  function automatic logic [c_idx_w-1:0] wrap_idx(input logic [c_idx_w:0] v);
    if (v >= c_ncores) begin
      return c_idx_w'(v - c_ncores);
    end
    return c_idx_w'(v);
  endfunction

  function automatic logic [NCORES-1:0] onehot(input logic [c_idx_w-1:0] idx);
    logic [NCORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // A core that was just served sits out one IDLE cycle so it can drop its line.
  assign w_elig = (bus.req_ld | bus.req_st) & ~r_holdoff;

  // Round-robin search: first eligible core at or above rr_ptr, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (!w_found && w_elig[wrap_idx({1'b0, r_rr_ptr} + (c_idx_w+1)'(i))]) begin
        w_found   = 1'b1;
        w_gnt_idx = wrap_idx({1'b0, r_rr_ptr} + (c_idx_w+1)'(i));
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one access per grant, fixed three-cycle cadence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, read-data capture, completion pulse and fairness bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_holdoff  <= '0;
      r_val_data <= '0;
      r_op_ld    <= 1'b0;
      r_addr_l   <= '0;
      r_wdata_l  <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_holdoff <= '0;
          if (w_found) begin
            r_gnt     <= w_gnt_idx;
            // Load wins when both lines are high for the granted core.
            r_op_ld   <= bus.req_ld[w_gnt_idx];
            r_addr_l  <= bus.addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
            r_wdata_l <= bus.wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
          end
        end
        S_ACCESS: begin
          r_val_data <= onehot(r_gnt);
          if (r_op_ld) begin
            r_rdata <= r_mem[r_addr_l];
          end
        end
        S_RESP: begin
          r_val_data <= '0;
          r_rr_ptr   <= wrap_idx({1'b0, r_gnt} + (c_idx_w+1)'(1));
          r_holdoff  <= onehot(r_gnt);
        end
        default: begin
          r_val_data <= '0;
        end
      endcase
    end
  end

  // RAM write port; a store whose ACCESS cycle meets reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_ACCESS) && !r_op_ld) begin
      r_mem[r_addr_l] <= r_wdata_l;
    end
  end

  assign bus.val_data = r_val_data;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = (r_state != S_IDLE);

`ifdef SHMEM_PERF_EN
  logic [15:0] r_ld_count;
  logic [15:0] r_st_count;

  // Saturating served-access counters, bumped once per completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_count <= '0;
      r_st_count <= '0;
    end else if (r_state == S_RESP) begin
      if (r_op_ld && (r_ld_count != 16'hFFFF)) begin
        r_ld_count <= r_ld_count + 16'd1;
      end
      if (!r_op_ld && (r_st_count != 16'hFFFF)) begin
        r_st_count <= r_st_count + 16'd1;
      end
    end
  end

  assign bus.ld_count = r_ld_count;
  assign bus.st_count = r_st_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_mem_responder
//  Description : Self-checking bench for shared_mem_responder. A transaction
//                level model (memory array, round-robin pointer, expected
//                service order, access counts) predicts every completion.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shared_mem_responder;

  localparam int NC = 16;
  localparam int AW = 12;
  localparam int DW = 8;

  localparam int M_OFF   = 0;  // line low
  localparam int M_ONE   = 1;  // drop on own val_data
  localparam int M_HOLD  = 2;  // keep line high
  localparam int M_REREQ = 3;  // drop on val_data, re-raise 4 cycles later

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  shared_mem_responder_if #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  shared_mem_responder #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0]  mem_m [4096];
  int          ptr_m = 0;
  int          ld_n = 0;
  int          st_n = 0;
  logic [7:0]  last_rd_m = 8'h00;

  // Per-core stimulus state
  bit          is_ld [NC];
  bit          is_st [NC];
  bit          act   [NC];
  bit          pend  [NC];
  logic [11:0] a_c   [NC];
  logic [7:0]  d_c   [NC];
  int          mode  [NC];
  int          cd    [NC];

  // Completions observed in the latest run
  int          p_core [$];
  int          p_cyc  [$];
  logic [15:0] p_vec  [$];
  logic [7:0]  p_rd   [$];
  int          exp_q  [$];
  logic [11:0] pool   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_lines();
    logic [NC-1:0]    ld;
    logic [NC-1:0]    st;
    logic [NC*AW-1:0] ad;
    logic [NC*DW-1:0] wd;
    for (int c = 0; c < NC; c++) begin
      ld[c]          = act[c] & is_ld[c];
      st[c]          = act[c] & is_st[c];
      ad[c*AW +: AW] = a_c[c];
      wd[c*DW +: DW] = d_c[c];
    end
    bus.req_ld = ld;
    bus.req_st = st;
    bus.addr   = ad;
    bus.wdata  = wd;
  endtask

  task automatic raise(input int c, input bit ld, input bit st, input logic [11:0] a,
                       input logic [7:0] d, input int m);
    is_ld[c] = ld;
    is_st[c] = st;
    a_c[c]   = a;
    d_c[c]   = d;
    mode[c]  = m;
    act[c]   = 1'b1;
    pend[c]  = 1'b1;
    cd[c]    = 0;
    apply_lines();
  endtask

  task automatic clear_all();
    for (int c = 0; c < NC; c++) begin
      act[c]  = 1'b0;
      pend[c] = 1'b0;
      mode[c] = M_OFF;
      cd[c]   = 0;
    end
    apply_lines();
  endtask

  task automatic model_reset();
    ptr_m     = 0;
    last_rd_m = 8'h00;
    ld_n      = 0;
    st_n      = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  // Advance up to max_cyc cycles, scoring every completion against the model.
  task automatic run(input int max_cyc, input int want);
    int got;
    int c;
    logic [15:0] v;
    got = 0;
    p_core.delete();
    p_cyc.delete();
    p_vec.delete();
    p_rd.delete();
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      for (int i = 0; i < NC; i++) begin
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) begin
            act[i]  = 1'b1;
            pend[i] = 1'b1;
          end
        end
      end
      v = bus.val_data;
      if (v !== 16'h0000) begin
        check("val_onehot", $countones(v), 1);
        c = 0;
        for (int i = 0; i < NC; i++) if (v[i] === 1'b1) c = i;
        check("val_to_requester", {31'd0, pend[c]}, 1);
        p_core.push_back(c);
        p_cyc.push_back(cyc);
        p_vec.push_back(v);
        p_rd.push_back(bus.rdata);
        if (is_ld[c]) begin
          check("load_rdata", bus.rdata, mem_m[a_c[c]]);
          last_rd_m = mem_m[a_c[c]];
          ld_n++;
        end else begin
          check("store_rdata_hold", bus.rdata, last_rd_m);
          mem_m[a_c[c]] = d_c[c];
          st_n++;
        end
        ptr_m = (c + 1) % NC;
        if (mode[c] == M_ONE) begin
          act[c]  = 1'b0;
          pend[c] = 1'b0;
          mode[c] = M_OFF;
        end else if (mode[c] == M_REREQ) begin
          act[c]  = 1'b0;
          pend[c] = 1'b0;
          cd[c]   = 4;
        end
        got++;
      end
      apply_lines();
      if (want > 0 && got >= want) break;
    end
    if (want > 0) check("pulse_count", got, want);
  endtask

  // Requests raised together from a quiet IDLE are served cyclically from the pointer.
  task automatic build_order(input logic [NC-1:0] m);
    exp_q.delete();
    for (int d = 0; d < NC; d++) begin
      if (m[(ptr_m + d) % NC]) exp_q.push_back((ptr_m + d) % NC);
    end
  endtask

  task automatic check_order(input string tag, input int s);
    check({tag, "_n"}, p_core.size(), exp_q.size());
    for (int k = 0; k < p_core.size() && k < exp_q.size(); k++) begin
      check({tag, "_core"}, p_core[k], exp_q[k]);
      check({tag, "_gap"}, p_cyc[k] - ((k == 0) ? s : p_cyc[k-1]), (k == 0) ? 2 : 3);
    end
  endtask

  task automatic check_counters();
`ifdef SHMEM_PERF_EN
    check("ld_count", bus.ld_count, ld_n);
    check("st_count", bus.st_count, st_n);
`endif
  endtask

  initial begin
    int s;
    int pos3;
    int n3;
    int n;
    int op;
    logic [NC-1:0] m;

    for (int c = 0; c < NC; c++) begin
      a_c[c] = '0;
      d_c[c] = '0;
    end
    clear_all();

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_val", bus.val_data, 16'h0000);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    tick();
    check("idle_val", bus.val_data, 16'h0000);
    check("idle_busy", bus.busy, 1'b0);
    check_counters();

    // Single store then load on core 2
    raise(2, 1'b0, 1'b1, 12'h0A5, 8'h3C, M_ONE);
    s = cyc;
    run(8, 1);
    if (p_cyc.size() > 0) check("st_latency", p_cyc[0] - s, 2);
    run(2, 0);
    raise(2, 1'b1, 1'b0, 12'h0A5, 8'h00, M_ONE);
    s = cyc;
    run(8, 1);
    if (p_cyc.size() > 0) begin
      check("ld_latency", p_cyc[0] - s, 2);
      check("ld_val_vec", p_vec[0], 16'h0004);
      check("ld_rdata_3c", p_rd[0], 8'h3C);
    end

    // Round-robin from reset: cores 0, 5, 15
    do_reset();
    raise(0, 1'b1, 1'b0, 12'h0A5, 8'h00, M_ONE);
    raise(5, 1'b1, 1'b0, 12'h0A5, 8'h00, M_ONE);
    raise(15, 1'b1, 1'b0, 12'h0A5, 8'h00, M_ONE);
    build_order(16'h8021);
    s = cyc;
    run(20, 3);
    check_order("rr", s);
    run(2, 0);

    // Fairness across the wrap: pointer parked at 15, cores 15 and 0 keep asking
    raise(14, 1'b0, 1'b1, 12'h123, 8'h5E, M_ONE);
    run(8, 1);
    run(2, 0);
    raise(15, 1'b1, 1'b0, 12'h0A5, 8'h00, M_REREQ);
    raise(0, 1'b1, 1'b0, 12'h0A5, 8'h00, M_REREQ);
    run(60, 6);
    for (int k = 0; k < p_core.size(); k++) check("fair_core", p_core[k], (k % 2 == 0) ? 15 : 0);
    clear_all();
    run(3, 0);

    // Store held high by core 7
    raise(7, 1'b0, 1'b1, 12'hFFF, 8'h81, M_HOLD);
    s = cyc;
    run(10, 0);
    check("hold_n", p_core.size(), 3);
    for (int k = 0; k < p_core.size(); k++) begin
      check("hold_core", p_core[k], 7);
      check("hold_gap", p_cyc[k] - ((k == 0) ? s : p_cyc[k-1]), (k == 0) ? 2 : 4);
    end
    raise(3, 1'b1, 1'b0, 12'h0A5, 8'h00, M_ONE);
    run(20, 0);
    pos3 = -1;
    n3 = 0;
    for (int k = 0; k < p_core.size(); k++) begin
      if (p_core[k] == 3) begin
        n3++;
        if (pos3 < 0) pos3 = k;
      end
    end
    check("hold_n3", n3, 1);
    check("hold_pos3", {31'd0, (pos3 >= 0 && pos3 <= 1)}, 1);
    mode[7] = M_ONE;
    run(10, 1);
    run(2, 0);
    raise(7, 1'b1, 1'b0, 12'hFFF, 8'h00, M_ONE);
    run(8, 1);
    if (p_rd.size() > 0) check("hold_fff", p_rd[0], 8'h81);

    // Reset landing on a store's ACCESS cycle
    run(2, 0);
    raise(1, 1'b0, 1'b1, 12'h010, 8'h55, M_ONE);
    run(8, 1);
    run(2, 0);
    raise(1, 1'b0, 1'b1, 12'h010, 8'hAA, M_ONE);
    tick();
    check("rma_busy_access", bus.busy, 1'b1);
    reset = 1'b1;
    clear_all();
    tick();
    check("rma_val", bus.val_data, 16'h0000);
    check("rma_busy", bus.busy, 1'b0);
    check("rma_rdata", bus.rdata, 8'h00);
    reset = 1'b0;
    model_reset();
    tick();
    check("rma_val_after", bus.val_data, 16'h0000);
    raise(1, 1'b1, 1'b0, 12'h010, 8'h00, M_ONE);
    run(8, 1);
    if (p_rd.size() > 0) check("rma_prior", p_rd[0], 8'h55);

    // Load and store together on core 3
    do_reset();
    raise(3, 1'b1, 1'b1, 12'h0A5, 8'h5A, M_ONE);
    run(8, 1);
    if (p_rd.size() > 0) check("dual_rdata", p_rd[0], 8'h3C);
`ifdef SHMEM_PERF_EN
    check("dual_ld_count", bus.ld_count, 16'd1);
    check("dual_st_count", bus.st_count, 16'd0);
`endif
    run(2, 0);
    raise(3, 1'b1, 1'b0, 12'h0A5, 8'h00, M_ONE);
    run(8, 1);
    if (p_rd.size() > 0) check("dual_ram_unchanged", p_rd[0], 8'h3C);
    run(2, 0);

    // Randomised bursts over a small address pool
    pool[0] = 12'h000;
    pool[1] = 12'hFFF;
    for (int i = 2; i < 8; i++) pool[i] = 12'($urandom_range(1, 4094));
    for (int i = 0; i < 8; i++) begin
      raise(int'($urandom_range(0, NC-1)), 1'b0, 1'b1, pool[i], 8'($urandom), M_ONE);
      run(8, 1);
      run(2, 0);
    end
    for (int it = 0; it < 15; it++) begin
      m = '0;
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) m[$urandom_range(0, NC-1)] = 1'b1;
      for (int c = 0; c < NC; c++) begin
        if (m[c]) begin
          op = int'($urandom_range(0, 2));
          raise(c, op != 1, op != 0, pool[$urandom_range(0, 7)], 8'($urandom), M_ONE);
        end
      end
      build_order(m);
      s = cyc;
      run($countones(m) * 3 + 6, $countones(m));
      check_order("rand", s);
      run(2, 0);
    end
    check_counters();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
